// File: rtl/blowfish128_ffunc.sv
// Blowfish-128 round function F: eight byte-indexed S-box reads through a shared
// read port, combined as add/xor/add per group of four, then folded into Y.
module blowfish128_ffunc #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        sbox_ready,
  input  logic        ffunc_enable,
  input  logic [63:0] X,
  output logic        ffunc_ready,
  output logic [63:0] Y,
  output logic        sbox_rd_en,
  output logic [1:0]  sbox_rd_sel,
  output logic [7:0]  sbox_rd_addr,
  input  logic [63:0] sbox_rd_data
);

  localparam int unsigned TagW = 3 * RD_LATENCY;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StDone,
    StWaitLow
  } state_e;

  state_e                  state_q, state_d;
  logic [63:0]             xr_q, xr_d;
  logic [2:0]              idx_q, idx_d;
  logic [63:0]             acc_q, acc_d;
  logic [63:0]             t1_q, t1_d;
  logic [63:0]             y_q, y_d;
  logic [RD_LATENCY-1:0]   pipe_v_q, pipe_v_d;
  logic [TagW-1:0]         pipe_tag_q, pipe_tag_d;

  logic                    in_flight;
  logic                    issue;
  logic                    flush;
  logic                    ret_v;
  logic [2:0]              ret_tag;
  logic [2:0]              byte_sel;
  logic [63:0]             acc_new;

  assign in_flight = (state_q == StRead) || (state_q == StDrain);
  assign issue     = (state_q == StRead) && ffunc_enable;
  assign flush     = in_flight && !ffunc_enable;
  assign ret_v     = pipe_v_q[RD_LATENCY-1] && in_flight && ffunc_enable;
  assign ret_tag   = pipe_tag_q[TagW-1 -: 3];
  assign byte_sel  = 3'd7 - idx_q;

  assign sbox_rd_en   = (state_q == StRead);
  assign sbox_rd_sel  = sbox_rd_en ? idx_q[1:0] : 2'd0;
  assign sbox_rd_addr = sbox_rd_en ? xr_q[{byte_sel, 3'b000} +: 8] : 8'h00;
  assign ffunc_ready  = (state_q == StDone);
  assign Y            = y_q;

  // Newest read enters at the bottom; the top stage lines up with returning data.
  always_comb begin
    pipe_v_d   = (pipe_v_q << 1) | RD_LATENCY'(issue);
    pipe_tag_d = (pipe_tag_q << 3) | TagW'(idx_q);
    if (flush) begin
      pipe_v_d = '0;
    end
  end

  always_comb begin
    acc_new = sbox_rd_data;
    case (ret_tag[1:0])
      2'd0:    acc_new = sbox_rd_data;
      2'd2:    acc_new = acc_q ^ sbox_rd_data;
      default: acc_new = acc_q + sbox_rd_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    t1_d    = t1_q;
    y_d     = y_q;

    unique case (state_q)
      StIdle: begin
        if (ffunc_enable && sbox_ready) begin
          xr_d    = X;
          idx_d   = 3'd0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (!ffunc_enable) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!ffunc_enable) begin
          state_d = StIdle;
        end
      end
      StDone: begin
        state_d = ffunc_enable ? StWaitLow : StIdle;
      end
      StWaitLow: begin
        if (!ffunc_enable) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (ret_v) begin
      acc_d = acc_new;
      if (ret_tag == 3'd3) begin
        t1_d = acc_new;
      end
      // Last return: fold the halves of T2 and publish the result.
      if (ret_tag == 3'd7) begin
        y_d     = t1_q ^ {acc_new[31:0], acc_new[63:32]};
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= StIdle;
      xr_q       <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      t1_q       <= '0;
      y_q        <= '0;
      pipe_v_q   <= '0;
      pipe_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      xr_q       <= xr_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      t1_q       <= t1_d;
      y_q        <= y_d;
      pipe_v_q   <= pipe_v_d;
      pipe_tag_q <= pipe_tag_d;
    end
  end

endmodule

// File: tb/tb_blowfish128_ffunc.sv
// Bench for blowfish128_ffunc: two instances (read latency 1 and 3) share stimulus
// and S-box contents; expected results are queued per instance and checked on each pulse.
module tb_blowfish128_ffunc;

  localparam int Lat0 = 9;
  localparam int Lat1 = 11;

  typedef struct {
    logic [63:0] y;
    int          start;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        sbox_ready = 1'b0;
  logic        ffunc_enable = 1'b0;
  logic [63:0] X = '0;

  logic        rdy0, rdy1, en0, en1;
  logic [63:0] y0, y1, rd0, rd1;
  logic [1:0]  sel0, sel1;
  logic [7:0]  addr0, addr1;

  logic [63:0] sbox [4][256];
  logic [63:0] rp0 [3];
  logic [63:0] rp1 [3];

  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          np0 = 0;
  int          np1 = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;
  logic        prev0 = 1'b0;
  logic        prev1 = 1'b0;
  logic [1:0]  done = 2'b00;
  logic [63:0] last_y = '0;
  logic        log_en = 1'b0;
  logic [9:0]  rlog[$];

  blowfish128_ffunc #(.RD_LATENCY(1)) u_dut0 (
    .Clk(Clk), .Rst(Rst), .sbox_ready(sbox_ready), .ffunc_enable(ffunc_enable), .X(X),
    .ffunc_ready(rdy0), .Y(y0), .sbox_rd_en(en0), .sbox_rd_sel(sel0),
    .sbox_rd_addr(addr0), .sbox_rd_data(rd0)
  );

  blowfish128_ffunc #(.RD_LATENCY(3)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .sbox_ready(sbox_ready), .ffunc_enable(ffunc_enable), .X(X),
    .ffunc_ready(rdy1), .Y(y1), .sbox_rd_en(en1), .sbox_rd_sel(sel1),
    .sbox_rd_addr(addr1), .sbox_rd_data(rd1)
  );

  always #5 Clk = ~Clk;

  // S-box storage model: data appears N cycles after the strobe cycle.
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    rp0[0] <= en0 ? sbox[sel0][addr0] : 64'hBAD0_BAD0_BAD0_BAD0;
    rp0[1] <= rp0[0];
    rp0[2] <= rp0[1];
    rp1[0] <= en1 ? sbox[sel1][addr1] : 64'hBAD1_BAD1_BAD1_BAD1;
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
    if (log_en && en0) rlog.push_back({sel0, addr0});
  end
  assign rd0 = rp0[0];
  assign rd1 = rp1[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] fref(input logic [63:0] x);
    logic [63:0] acc, t1, d;
    logic [7:0]  b;
    acc = '0;
    t1  = '0;
    for (int k = 0; k < 8; k++) begin
      b = x[8*(7-k) +: 8];
      d = sbox[k % 4][b];
      case (k % 4)
        0:       acc = d;
        2:       acc = acc ^ d;
        default: acc = acc + d;
      endcase
      if (k == 3) t1 = acc;
    end
    return t1 ^ {acc[31:0], acc[63:32]};
  endfunction

  task automatic fill(input int mode);
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 256; i++) begin
        case (mode)
          0: sbox[b][i] = '0;
          1: sbox[b][i] = (b == 0) ? 64'(i) : 64'h0;
          2: sbox[b][i] = (b == 0) ? 64'h1 : ((b == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
          default: sbox[b][i] = {$urandom, $urandom};
        endcase
      end
    end
  endtask

  always @(negedge Clk) begin
    if (rdy0) begin
      check("single_pulse0", prev0, 1'b0);
      check("pulse_expected0", q0.size() != 0, 1'b1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check("y0", y0, e0.y);
        check("latency0", cyc - e0.start, Lat0);
        done[0] = 1'b1;
      end
      np0++;
    end
    prev0 = rdy0;
  end

  always @(negedge Clk) begin
    if (rdy1) begin
      check("single_pulse1", prev1, 1'b0);
      check("pulse_expected1", q1.size() != 0, 1'b1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("y1", y1, e1.y);
        check("latency1", cyc - e1.start, Lat1);
        done[1] = 1'b1;
      end
      np1++;
    end
    prev1 = rdy1;
  end

  // Core-style request: hold enable until both results arrive, then drop it.
  task automatic do_txn(input logic [63:0] x, input logic [63:0] ey, input int hold);
    int n, rcnt;
    X = x;
    ffunc_enable = 1'b1;
    sbox_ready = 1'b1;
    done = 2'b00;
    q0.push_back('{y: ey, start: cyc + 1});
    q1.push_back('{y: ey, start: cyc + 1});
    n = 0;
    while (done != 2'b11 && n < 60) begin
      @(posedge Clk); #2;
      n++;
      X = {$urandom, $urandom};
      sbox_ready = 1'($urandom_range(0, 1));
    end
    check("complete", done, 2'b11);
    rcnt = 0;
    repeat (hold) begin
      @(posedge Clk); #2;
      rcnt += int'(en0 | en1);
    end
    check("no_restart", rcnt, 0);
    ffunc_enable = 1'b0;
    sbox_ready = 1'b1;
    @(posedge Clk); #2;
    last_y = ey;
  endtask

  initial begin
    logic [63:0] xs;
    logic [9:0]  er;
    int          cnt, pulses;

    fill(0);
    repeat (3) @(posedge Clk);
    #2;
    check("reset_y0", y0, 64'h0);
    check("reset_y1", y1, 64'h0);
    check("reset_ctl0", {en0, rdy0, sel0, addr0}, 0);
    check("reset_ctl1", {en1, rdy1, sel1, addr1}, 0);
    Rst = 1'b0;
    @(posedge Clk); #2;

    xs = 64'h0123_4567_89AB_CDEF;
    rlog.delete();
    log_en = 1'b1;
    do_txn(xs, 64'h0, 1);
    log_en = 1'b0;
    check("rd_count", rlog.size(), 8);
    if (rlog.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        er = {k[1:0], xs[8*(7-k) +: 8]};
        check("rd_seq", rlog[k], er);
      end
    end

    fill(1);
    do_txn(64'hAB00_0000_CD00_0000, 64'h0000_00CD_0000_00AB, 0);

    fill(2);
    do_txn({$urandom, $urandom}, 64'h0, 2);

    sbox_ready = 1'b0;
    ffunc_enable = 1'b1;
    X = {$urandom, $urandom};
    cnt = 0;
    repeat (6) begin
      @(posedge Clk); #2;
      cnt += int'(en0 | en1);
    end
    check("gated_start", cnt, 0);
    ffunc_enable = 1'b0;
    @(posedge Clk); #2;

    fill(3);
    for (int t = 0; t < 20; t++) begin
      if (t % 5 == 4) fill(3);
      xs = {$urandom, $urandom};
      do_txn(xs, fref(xs), $urandom_range(0, 3));
    end

    pulses = np0 + np1;
    X = {$urandom, $urandom};
    sbox_ready = 1'b1;
    ffunc_enable = 1'b1;
    @(posedge Clk);
    repeat (4) @(posedge Clk);
    #2 ffunc_enable = 1'b0;
    repeat (15) @(posedge Clk);
    #2;
    check("abort_pulses", np0 + np1, pulses);
    check("abort_y0", y0, last_y);
    check("abort_y1", y1, last_y);

    X = {$urandom, $urandom};
    ffunc_enable = 1'b1;
    @(posedge Clk);
    repeat (2) @(posedge Clk);
    #3 Rst = 1'b1;
    #1;
    check("midrst_y0", y0, 64'h0);
    check("midrst_y1", y1, 64'h0);
    check("midrst_ctl0", {en0, rdy0, sel0, addr0}, 0);
    check("midrst_ctl1", {en1, rdy1, sel1, addr1}, 0);
    @(posedge Clk); #2;
    Rst = 1'b0;
    ffunc_enable = 1'b0;
    @(posedge Clk); #2;

    xs = {$urandom, $urandom};
    do_txn(xs, fref(xs), 1);
    repeat (5) @(posedge Clk);
    #2;
    check("queues_empty", q0.size() + q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/blowfish128_ffunc.md
Name: blowfish128_ffunc

Overview:
- Computes the Blowfish-128 round function F for the encrypt/decrypt core.
- Receives the 64-bit round input X over a level-enable handshake and returns the 64-bit result Y.
- Y is built from eight byte-indexed S-box lookups through a shared S-box read port, which is owned by the subkey/S-box storage.
- Sequential design: it issues one lookup per cycle and accumulates the results.

Parameters:
RD_LATENCY, 1, S-box read latency in cycles from sbox_rd_en to sbox_rd_data valid; legal values 1..3.

Ports:
Clk  input  1  clock, all logic on rising edge
Rst  input  1  asynchronous active-high reset
sbox_ready  input  1  S-box contents valid; while low, ffunc_enable is ignored
ffunc_enable  input  1  request from core; held high with X stable until ffunc_ready is seen
X  input  64  round input, sampled on the start edge
ffunc_ready  output  1  one-cycle pulse, Y valid
Y  output  64  F(X), held until the next result
sbox_rd_en  output  1  S-box read strobe
sbox_rd_sel  output  2  S-box select 0..3
sbox_rd_addr  output  8  S-box entry index
sbox_rd_data  input  64  read data, valid RD_LATENCY cycles after its strobe

Behaviour:
- Reset (async, Rst=1): state=IDLE; ffunc_ready=0, Y=0, sbox_rd_en=0, sbox_rd_sel=0, sbox_rd_addr=0; all counters and accumulators = 0. Reset mid-computation discards all work and produces no pulse.
- States: IDLE, READ, DRAIN, DONE, WAITLOW.
- IDLE: on an edge with ffunc_enable=1 and sbox_ready=1, latch X into xr, set idx=0, go to READ.
- Byte order: B7=xr[63:56] down to B0=xr[7:0]. Read k (k=0..7) uses byte B(7-k) and box k mod 4.
- READ: sbox_rd_en=1 (combinational on state), sbox_rd_sel=idx[1:0], sbox_rd_addr=B(7-idx). idx increments every cycle. After the idx=7 edge, go to DRAIN.
- Read tracking: a valid/tag delay line of depth RD_LATENCY tracks each returning read k.
- Accumulation on return of read k, with d=sbox_rd_data:
  - k mod 4 = 0: acc = d
  - k mod 4 = 1: acc = acc + d (mod 2^64)
  - k mod 4 = 2: acc = acc ^ d
  - k mod 4 = 3: acc = acc + d (mod 2^64)
  - k=3: T1 = acc. k=7: T2 = acc.
- Result: Y = T1 ^ {T2[31:0], T2[63:32]}. All adds wrap; no carries are retained.
- DRAIN: hold for RD_LATENCY cycles until read 7 returns. On the edge where the T2 accumulation completes, register Y, set ffunc_ready=1, go to DONE.
- Latency: ffunc_ready is high in the cycle 9+(RD_LATENCY-1) clock edges after the start edge. With RD_LATENCY=1 this is 9 edges.
- DONE: lasts exactly one cycle, then ffunc_ready=0. Go to WAITLOW, or directly to IDLE if ffunc_enable is already 0.
  - ffunc_ready must never be high two consecutive cycles. The core consumes on every edge where ready=1.
- WAITLOW: stay until ffunc_enable=0, then go to IDLE. A still-high enable left over from the finished request never restarts a computation.
- Abort: ffunc_enable=0 while in READ or DRAIN returns to IDLE at that edge. No ready pulse; Y is unchanged. In-flight read returns are dropped.
- sbox_ready falling mid-computation: no effect on the current computation; it only gates starts.
- X changing after the start edge: no effect (xr is latched).

Test Plan:
- All S-boxes return 0, X=64'h0123_4567_89AB_CDEF, enable held -> exactly one ready pulse 9 edges after start (RD_LATENCY=1); Y=0; 8 reads with sel 0,1,2,3,0,1,2,3 and addr 01,23,45,67,89,AB,CD,EF.
- S0[i]=i, S1..S3=0, X=64'hAB00_0000_CD00_0000 -> Y=64'h0000_00CD_0000_00AB.
- Wrap test: S0[i]=1, S1[i]=64'hFFFF_FFFF_FFFF_FFFF, S2=S3=0, any X -> Y=0.
- Back-to-back: core-style driver drops enable on the ready edge and reasserts next cycle with a new X -> second result correct; no duplicate pulse; no restart while in WAITLOW.
- Abort: deassert enable at read 4 -> no pulse, Y unchanged. Then assert Rst mid-READ -> all outputs 0 immediately; a new request completes normally.
- RD_LATENCY=3 with a delayed S-box model, S0[i]=i -> same Y as scenario 2; pulse at edge 11.
